// File: rtl/rtc_hms.sv
// rtc_hms: 24-hour h:m:s real-time clock with range-checked load, pause, 12/24-hour BCD and 7-seg display.
// Optional alarm enabled by defining ALARM_EN; otherwise alarm is tied low.

module Led_num (
  input  logic [3:0] num,
  output logic [6:0] seg
);
  // Active-low segments, bit order gfedcba.
  always_comb begin
    seg = 7'b1111111;
    case (num)
      4'd0: seg = 7'b1000000;
      4'd1: seg = 7'b1111001;
      4'd2: seg = 7'b0100100;
      4'd3: seg = 7'b0110000;
      4'd4: seg = 7'b0011001;
      4'd5: seg = 7'b0010010;
      4'd6: seg = 7'b0000010;
      4'd7: seg = 7'b1111000;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end
endmodule

module rtc_hms #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic       clk_50,
  input  logic       clr,
  input  logic       run,
  input  logic       load,
  input  logic [4:0] h,
  input  logic [5:0] m,
  input  logic [5:0] s,
  input  logic       mode12,
  input  logic       al_set,
  input  logic       al_ack,
  output logic       fault,
  output logic       sec_tick,
  output logic       pm,
  output logic [3:0] hr_t,
  output logic [3:0] hr_u,
  output logic [3:0] mn_t,
  output logic [3:0] mn_u,
  output logic [3:0] sc_t,
  output logic [3:0] sc_u,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [6:0] HEX4,
  output logic [6:0] HEX5,
  output logic       alarm
);
  localparam int PW = $clog2(CLK_DIV);

  logic [PW-1:0] pre_q, pre_d;
  logic [4:0]    h_q, h_d;
  logic [5:0]    m_q, m_d, s_q, s_d;
  logic          do_load, s_wrap, m_wrap;
  logic [4:0]    disp_h;

  assign fault    = (h >= 5'd24) || (m >= 6'd60) || (s >= 6'd60);
  assign sec_tick = run && (pre_q == PW'(CLK_DIV - 1));
  assign do_load  = load && !fault;
  assign s_wrap   = s_q == 6'd59;
  assign m_wrap   = m_q == 6'd59;

  // A valid load overrides a coincident tick; a faulted load falls through to normal counting.
  always_comb begin
    pre_d = pre_q;
    h_d   = h_q;
    m_d   = m_q;
    s_d   = s_q;
    if (do_load) begin
      pre_d = '0;
      h_d   = h;
      m_d   = m;
      s_d   = s;
    end else if (sec_tick) begin
      pre_d = '0;
      s_d   = s_wrap ? 6'd0 : s_q + 6'd1;
      m_d   = s_wrap ? (m_wrap ? 6'd0 : m_q + 6'd1) : m_q;
      h_d   = (s_wrap && m_wrap) ? (h_q == 5'd23 ? 5'd0 : h_q + 5'd1) : h_q;
    end else if (run) begin
      pre_d = pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk_50 or negedge clr) begin
    if (!clr) begin
      pre_q <= '0;
      h_q   <= '0;
      m_q   <= '0;
      s_q   <= '0;
    end else begin
      pre_q <= pre_d;
      h_q   <= h_d;
      m_q   <= m_d;
      s_q   <= s_d;
    end
  end

  assign pm     = h_q >= 5'd12;
  assign disp_h = !mode12 ? h_q : (h_q == 5'd0) ? 5'd12 : (h_q > 5'd12) ? h_q - 5'd12 : h_q;
  assign hr_t   = 4'(disp_h / 5'd10);
  assign hr_u   = 4'(disp_h % 5'd10);
  assign mn_t   = 4'(m_q / 6'd10);
  assign mn_u   = 4'(m_q % 6'd10);
  assign sc_t   = 4'(s_q / 6'd10);
  assign sc_u   = 4'(s_q % 6'd10);

  Led_num u_hex0 (.num(hr_t), .seg(HEX0));
  Led_num u_hex1 (.num(hr_u), .seg(HEX1));
  Led_num u_hex2 (.num(mn_t), .seg(HEX2));
  Led_num u_hex3 (.num(mn_u), .seg(HEX3));
  Led_num u_hex4 (.num(sc_t), .seg(HEX4));
  Led_num u_hex5 (.num(sc_u), .seg(HEX5));

`ifdef ALARM_EN
  logic [4:0] al_h_q;
  logic [5:0] al_m_q;
  logic       alarm_q, al_fault, al_hit, min_roll;

  assign al_fault = (h >= 5'd24) || (m >= 6'd60);
  assign al_hit   = (do_load || sec_tick) && (s_d == 6'd0) && (h_d == al_h_q) && (m_d == al_m_q);
  assign min_roll = sec_tick && !do_load && s_wrap;

  always_ff @(posedge clk_50 or negedge clr) begin
    if (!clr) begin
      al_h_q  <= '0;
      al_m_q  <= '0;
      alarm_q <= 1'b0;
    end else begin
      if (al_set && !al_fault) begin
        al_h_q <= h;
        al_m_q <= m;
      end
      alarm_q <= al_hit ? 1'b1 : (al_ack || min_roll) ? 1'b0 : alarm_q;
    end
  end

  assign alarm = alarm_q;
`else
  logic unused_al;
  assign unused_al = ^{al_set, al_ack};
  assign alarm     = 1'b0;
`endif
endmodule

// File: tb/tb_rtc_hms.sv
// tb_rtc_hms: directed self-checking bench for rtc_hms with CLK_DIV = 4.
// Alarm scenarios run when ALARM_EN is defined; otherwise alarm is checked to stay low.

module tb_rtc_hms;
  logic       clk_50 = 1'b0;
  logic       clr, run, load, mode12, al_set, al_ack;
  logic [4:0] h;
  logic [5:0] m, s;
  logic       fault, sec_tick, pm, alarm;
  logic [3:0] hr_t, hr_u, mn_t, mn_u, sc_t, sc_u;
  logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  int         n_cmp = 0;
  int         n_bad = 0;

  rtc_hms #(.CLK_DIV(4)) dut (
    .clk_50(clk_50), .clr(clr), .run(run), .load(load), .h(h), .m(m), .s(s),
    .mode12(mode12), .al_set(al_set), .al_ack(al_ack), .fault(fault),
    .sec_tick(sec_tick), .pm(pm), .hr_t(hr_t), .hr_u(hr_u), .mn_t(mn_t),
    .mn_u(mn_u), .sc_t(sc_t), .sc_u(sc_u), .HEX0(HEX0), .HEX1(HEX1),
    .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5), .alarm(alarm)
  );

  always #5 clk_50 = ~clk_50;

  wire [23:0] digits = {hr_t, hr_u, mn_t, mn_u, sc_t, sc_u};

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_50);
    #2;
  endtask

  task automatic do_load(input logic [4:0] lh, input logic [5:0] lm, input logic [5:0] ls);
    h = lh; m = lm; s = ls; load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic test_reset;
    clr = 1'b0; run = 1'b0; load = 1'b0; mode12 = 1'b0; al_set = 1'b0; al_ack = 1'b0;
    h = '0; m = '0; s = '0;
    cyc(2);
    clr = 1'b1;
    cyc(1);
    n_cmp++; if (digits !== 24'h000000) begin n_bad++; $display("FAIL reset_digits got %h want 000000", digits); end
    n_cmp++; if ({sec_tick, pm, alarm, fault} !== 4'b0000) begin n_bad++; $display("FAIL reset_flags got %b want 0000", {sec_tick, pm, alarm, fault}); end
    n_cmp++; if ({HEX0, HEX2, HEX5} !== {3{7'b1000000}}) begin n_bad++; $display("FAIL reset_hex got %h want all 40", {HEX0, HEX2, HEX5}); end
    mode12 = 1'b1; #1;
    n_cmp++; if ({hr_t, hr_u} !== 8'h12) begin n_bad++; $display("FAIL reset_mode12 got %h want 12", {hr_t, hr_u}); end
    n_cmp++; if ({HEX0, HEX1} !== {7'b1111001, 7'b0100100}) begin n_bad++; $display("FAIL reset_hex12 got %h %h want 79 24", HEX0, HEX1); end
    mode12 = 1'b0;
  endtask

  task automatic test_count;
    run = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      n_cmp++; if (sec_tick !== (i % 4 == 3)) begin n_bad++; $display("FAIL tick_cycle%0d got %b want %b", i, sec_tick, (i % 4 == 3)); end
    end
    n_cmp++; if (digits !== 24'h000003) begin n_bad++; $display("FAIL count_3s got %h want 000003", digits); end
  endtask

  task automatic test_rollover;
    do_load(5'd23, 6'd59, 6'd58);
    n_cmp++; if ({digits, pm} !== {24'h235958, 1'b1}) begin n_bad++; $display("FAIL load_235958 got %h pm %b", digits, pm); end
    n_cmp++; if ({HEX4, HEX5} !== {7'b0010010, 7'b0000000}) begin n_bad++; $display("FAIL hex_58 got %h %h want 12 00", HEX4, HEX5); end
    cyc(3);
    n_cmp++; if (sec_tick !== 1'b1) begin n_bad++; $display("FAIL tick_after_load got %b want 1", sec_tick); end
    cyc(1);
    n_cmp++; if ({digits, pm} !== {24'h235959, 1'b1}) begin n_bad++; $display("FAIL to_235959 got %h pm %b", digits, pm); end
    cyc(4);
    n_cmp++; if ({digits, pm} !== {24'h000000, 1'b0}) begin n_bad++; $display("FAIL wrap_000000 got %h pm %b", digits, pm); end
    cyc(3);
    n_cmp++; if (sec_tick !== 1'b1) begin n_bad++; $display("FAIL tick_before_load got %b want 1", sec_tick); end
    do_load(5'd10, 6'd20, 6'd30);
    n_cmp++; if (digits !== 24'h102030) begin n_bad++; $display("FAIL load_on_tick got %h want 102030", digits); end
    cyc(3);
    n_cmp++; if (sec_tick !== 1'b1) begin n_bad++; $display("FAIL tick_after_load2 got %b want 1", sec_tick); end
    cyc(1);
    n_cmp++; if (digits !== 24'h102031) begin n_bad++; $display("FAIL after_load_tick got %h want 102031", digits); end
  endtask

  task automatic test_fault;
    run = 1'b0;
    h = 5'd24; m = 6'd10; s = 6'd0; #1;
    n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL fault_h24 got %b want 1", fault); end
    do_load(5'd24, 6'd10, 6'd0);
    n_cmp++; if (digits !== 24'h102031) begin n_bad++; $display("FAIL ignore_h24 got %h want 102031", digits); end
    h = 5'd5; s = 6'd60; #1;
    n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL fault_s60 got %b want 1", fault); end
    do_load(5'd5, 6'd10, 6'd60);
    n_cmp++; if (digits !== 24'h102031) begin n_bad++; $display("FAIL ignore_s60 got %h want 102031", digits); end
    m = 6'd60; s = 6'd0; #1;
    n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL fault_m60 got %b want 1", fault); end
    h = 5'd23; m = 6'd59; s = 6'd59; #1;
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL fault_max_legal got %b want 0", fault); end
  endtask

  task automatic test_mode12;
    run = 1'b0; mode12 = 1'b1;
    do_load(5'd0, 6'd15, 6'd0);
    n_cmp++; if ({digits, pm} !== {24'h121500, 1'b0}) begin n_bad++; $display("FAIL m12_0015 got %h pm %b", digits, pm); end
    mode12 = 1'b0; #1;
    n_cmp++; if ({hr_t, hr_u} !== 8'h00) begin n_bad++; $display("FAIL m24_0015 got %h want 00", {hr_t, hr_u}); end
    mode12 = 1'b1;
    do_load(5'd12, 6'd0, 6'd0);
    n_cmp++; if ({digits, pm} !== {24'h120000, 1'b1}) begin n_bad++; $display("FAIL m12_1200 got %h pm %b", digits, pm); end
    do_load(5'd13, 6'd5, 6'd0);
    n_cmp++; if ({digits, pm} !== {24'h010500, 1'b1}) begin n_bad++; $display("FAIL m12_1305 got %h pm %b", digits, pm); end
    mode12 = 1'b0; #1;
    n_cmp++; if ({hr_t, hr_u, pm} !== {8'h13, 1'b1}) begin n_bad++; $display("FAIL m24_1305 got %h pm %b", {hr_t, hr_u}, pm); end
    mode12 = 1'b1;
    do_load(5'd23, 6'd0, 6'd0);
    n_cmp++; if ({hr_t, hr_u} !== 8'h11) begin n_bad++; $display("FAIL m12_2300 got %h want 11", {hr_t, hr_u}); end
    mode12 = 1'b0;
  endtask

  task automatic test_pause;
    run = 1'b1;
    do_load(5'd0, 6'd0, 6'd0);
    cyc(2);
    run = 1'b0;
    cyc(10);
    n_cmp++; if ({digits, sec_tick} !== {24'h000000, 1'b0}) begin n_bad++; $display("FAIL paused got %h tick %b", digits, sec_tick); end
    run = 1'b1;
    cyc(1);
    n_cmp++; if ({digits, sec_tick} !== {24'h000000, 1'b1}) begin n_bad++; $display("FAIL resume_tick got %h tick %b want 000000 1", digits, sec_tick); end
    cyc(1);
    n_cmp++; if (digits !== 24'h000001) begin n_bad++; $display("FAIL resume_sec got %h want 000001", digits); end
  endtask

  task automatic test_reset_mid;
    run = 1'b1;
    do_load(5'd0, 6'd0, 6'd5);
    cyc(1);
    clr = 1'b0; #1;
    n_cmp++; if (digits !== 24'h000000) begin n_bad++; $display("FAIL async_clear got %h want 000000", digits); end
    cyc(1);
    clr = 1'b1;
    cyc(3);
    n_cmp++; if ({digits, sec_tick} !== {24'h000000, 1'b1}) begin n_bad++; $display("FAIL post_reset_tick got %h tick %b", digits, sec_tick); end
    cyc(1);
    n_cmp++; if (digits !== 24'h000001) begin n_bad++; $display("FAIL post_reset_sec got %h want 000001", digits); end
  endtask

  task automatic test_alarm;
`ifdef ALARM_EN
    run = 1'b0;
    h = 5'd7; m = 6'd30; al_set = 1'b1;
    cyc(1);
    al_set = 1'b0; run = 1'b1;
    do_load(5'd7, 6'd29, 6'd59);
    cyc(3);
    n_cmp++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL alarm_early got %b want 0", alarm); end
    cyc(1);
    n_cmp++; if ({digits, alarm} !== {24'h073000, 1'b1}) begin n_bad++; $display("FAIL alarm_set got %h alarm %b", digits, alarm); end
    al_ack = 1'b1;
    cyc(1);
    al_ack = 1'b0;
    n_cmp++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL alarm_ack got %b want 0", alarm); end
    do_load(5'd7, 6'd30, 6'd0);
    n_cmp++; if (alarm !== 1'b1) begin n_bad++; $display("FAIL alarm_on_load got %b want 1", alarm); end
    cyc(4 * 59);
    n_cmp++; if ({digits, alarm} !== {24'h073059, 1'b1}) begin n_bad++; $display("FAIL alarm_hold got %h alarm %b", digits, alarm); end
    cyc(4);
    n_cmp++; if ({digits, alarm} !== {24'h073100, 1'b0}) begin n_bad++; $display("FAIL alarm_rollover got %h alarm %b", digits, alarm); end
`else
    run = 1'b1;
    h = 5'd7; m = 6'd30; al_set = 1'b1;
    cyc(1);
    al_set = 1'b0;
    do_load(5'd7, 6'd29, 6'd59);
    cyc(4);
    n_cmp++; if ({digits, alarm} !== {24'h073000, 1'b0}) begin n_bad++; $display("FAIL alarm_disabled got %h alarm %b", digits, alarm); end
    do_load(5'd7, 6'd30, 6'd0);
    n_cmp++; if (alarm !== 1'b0) begin n_bad++; $display("FAIL alarm_disabled_load got %b want 0", alarm); end
`endif
  endtask

  initial begin
    test_reset;
    test_count;
    test_rollover;
    test_fault;
    test_mode12;
    test_pause;
    test_reset_mid;
    test_alarm;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rtc_hms.md
# rtc_hms

Parametrised real-time clock for the DE-board lab designs. Keeps hours:minutes:seconds in 24-hour form, loads a user time with range checking, and pauses on command. Shows the time as BCD digits and on six seven-segment displays in 12- or 24-hour format. It is the next-generation wall-clock block: a configurable prescaler, seconds display, correct rollover and an optional alarm.

## Interface
Parameters:
- CLK_DIV, 50_000_000, clk_50 cycles per second; legal range ≥ 2; prescaler width is $clog2(CLK_DIV)

Ports:
- clk_50  in  1  system clock
- clr  in  1  asynchronous, active-low reset
- run  in  1  1 = time advances; 0 = frozen, prescaler held
- load  in  1  synchronous load of h/m/s when fault = 0
- h  in  5  hour to load, 0–23
- m  in  6  minute to load, 0–59
- s  in  6  second to load, 0–59
- mode12  in  1  display format: 1 = 12-hour, 0 = 24-hour
- al_set  in  1  latch h/m as the alarm time (ALARM_EN only)
- al_ack  in  1  clear an active alarm (ALARM_EN only)
- fault  out  1  combinational: h ≥ 24 or m ≥ 60 or s ≥ 60
- sec_tick  out  1  one-cycle pulse on each one-second advance
- pm  out  1  count_h ≥ 12
- hr_t, hr_u, mn_t, mn_u, sc_t, sc_u  out  4 each  BCD display digits
- HEX0..HEX5  out  7 each  segments via the existing Led_num decoder: HEX0 = hr_t, HEX1 = hr_u, HEX2 = mn_t, HEX3 = mn_u, HEX4 = sc_t, HEX5 = sc_u
- alarm  out  1  alarm active

## Operation
- State: prescaler `pre`, count_h (5 bits), count_m (6 bits), count_s (6 bits). Internal time is always 24-hour.
- sec_tick = run && (pre == CLK_DIV-1). It is decoded from registers.
- Each edge resolves in priority order; the first matching row wins:
  1. load && !fault: load count_h/m/s from h/m/s and clear pre. No tick occurs that cycle, even if sec_tick is high.
  2. load && fault: the load is ignored, and counting proceeds as if load were 0.
  3. sec_tick: clear pre and advance the time.
     - count_s 59 → 0 and increments count_m.
     - count_m 59 → 0 and increments count_h.
     - count_h 23 → 0.
     - So 23:59:59 → 00:00:00 in a single edge.
  4. run: increment pre.
  5. !run: hold everything.
- Counters never hold values ≥ 24 / 60 / 60.
- Display digits are combinational from the counters.
  - mode12 = 0: displayed hour is count_h.
  - mode12 = 1: displayed hour is 12 when count_h is 0 or 12; count_h − 12 when count_h is 13–23; otherwise count_h.
  - hr_t / hr_u is the tens/units split of the displayed hour. pm is independent of mode12.
- mode12 affects the display only; it never changes the stored time.

## Timing
- Reset (clr low, asynchronous): pre, count_h/m/s = 0, alarm = 0; alarm time register = 0:00 (ALARM_EN).
  - With inputs idle after reset: sec_tick = 0, pm = 0, all digits 0 (mode12 = 0) or hour digits 1 and 2 (mode12 = 1).
- Reset asserted mid-count: immediate clear, no partial update. After release, the first sec_tick occurs CLK_DIV cycles after the first edge with run = 1.
- Load latency: 1 edge. The first tick after a load comes CLK_DIV cycles later, given run held at 1.
- run deasserted with pre = k: pre stays at k. Resuming continues from k; no time is lost or gained.
- fault is combinational with zero latency and has no effect on the state apart from blocking load.

## Configuration
- ALARM_EN defined:
  - al_set && !fault latches h/m into the alarm registers in 1 edge. Only the h ≥ 24 and m ≥ 60 terms of fault apply to al_set.
  - alarm sets on the edge where the time becomes HH:MM:00 with HH:MM equal to the alarm time. This covers both a tick and a load.
  - alarm clears on al_ack, or on the next minute rollover, whichever comes first. If both set and clear conditions occur on the same edge, set wins.
- ALARM_EN undefined: the alarm registers do not exist, alarm is tied to 0, and al_set / al_ack are ignored. The ports remain present.

## Test plan
- Reset, then run = 1 with CLK_DIV = 4: sec_tick pulses every 4 cycles; after 3 pulses sc_u = 3 and all other digits are 0.
- Load 23:59:58, run two seconds: shows 23:59:59, then 00:00:00 with pm going 1 → 0. Load asserted on a sec_tick cycle: the loaded value wins and no increment is applied.
- Load h = 24, m = 10, s = 0: fault = 1 and the time is unchanged. Repeat with s = 60: fault = 1, also ignored.
- mode12 = 1 with loads of 00:15:00, 12:00:00 and 13:05:00: hours display 12/pm = 0, 12/pm = 1, and 01/pm = 1. count_h reads 0, 12 and 13 respectively.
- Hold run = 0 for 10 cycles mid-second: pre and the time are frozen. After resuming, the next tick lands after the remaining cycles.
- ALARM_EN: al_set with 07:30, load 07:29:59, tick once: alarm = 1 at 07:30:00. al_ack clears it. Without al_ack, alarm clears at 07:31:00. Undefined build: alarm stays 0 throughout.
